// File: rtl/rm_lane_sequencer.sv
// Purpose: buffers per-detector lane hits, round-robin grants one per cycle into a per-lane step table, emits a token on chain completion.
// Latency: probe at t -> slot at t+1 -> earliest grant t+1 -> step/match visible t+2.
// Backpressure: match_valid_o & ~match_ready_i stalls grants; capture continues and a full slot drops the hit (sticky overflow_o).
module rm_lane_sequencer #(
    parameter int NUM_DET   = 4,
    parameter int NUM_LANES = 5,
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
    localparam int SW = $clog2(NUM_DET + 1),
    localparam int PW = $clog2(NUM_DET),
    localparam int CW = LW + 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    // per detector k, CW bits at k*CW: {probe_val, lane[LW-1:0], reset_lane}
    input  logic [NUM_DET*CW-1:0] lane_cnt_i,
    output logic                  match_valid_o,
    input  logic                  match_ready_i,
    output logic [LW-1:0]         match_lane_o,
    output logic                  overflow_o,
    input  logic                  overflow_clr_i,
    output logic                  busy_o
);

    logic [NUM_DET-1:0]   probe_val;
    logic [NUM_DET-1:0]   reset_lane;
    logic [NUM_DET-1:0]   lane_ok;
    logic [LW-1:0]        hit_lane [NUM_DET];

    logic [NUM_DET-1:0]   pending;
    logic [LW-1:0]        plane [NUM_DET];
    logic [SW-1:0]        step [NUM_LANES];
    logic [PW-1:0]        rr_ptr;
    logic                 match_vld_q;
    logic [LW-1:0]        match_lane_q;
    logic                 overflow_q;

    logic                 stall;
    logic                 gnt_vld;
    logic [PW-1:0]        gnt_idx;
    logic [NUM_DET-1:0]   gnt_hot;
    logic [NUM_LANES-1:0] lane_rst;
    logic [LW-1:0]        g_lane;
    logic                 g_lane_ok;
    logic [SW-1:0]        g_step;
    logic                 g_rst;
    logic                 g_adv;
    logic                 g_last;
    logic                 new_match;
    logic [SW-1:0]        next_step;
    logic [PW-1:0]        next_rr;
    logic [NUM_DET-1:0]   capture;
    logic [NUM_DET-1:0]   drop;

    always_comb begin
        for (int k = 0; k < NUM_DET; k++) begin
            reset_lane[k] = lane_cnt_i[k*CW];
            hit_lane[k]   = lane_cnt_i[k*CW+1 +: LW];
            probe_val[k]  = lane_cnt_i[k*CW+CW-1];
            lane_ok[k]    = 32'(hit_lane[k]) < NUM_LANES;
        end
    end

    assign stall = match_vld_q & ~match_ready_i;

    // Round-robin search starting at rr_ptr, wrapping.
    always_comb begin
        int idx;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        if (!stall) begin
            for (int i = 0; i < NUM_DET; i++) begin
                idx = (32'(rr_ptr) + i) % NUM_DET;
                if (!gnt_vld && pending[idx]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = PW'(idx);
                end
            end
        end
        for (int k = 0; k < NUM_DET; k++) begin
            gnt_hot[k] = gnt_vld && (32'(gnt_idx) == k);
        end
    end

    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            lane_rst[l] = 1'b0;
            for (int k = 0; k < NUM_DET; k++) begin
                if (reset_lane[k] && lane_ok[k] && (32'(hit_lane[k]) == l)) begin
                    lane_rst[l] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        g_lane    = plane[gnt_idx];
        g_lane_ok = 32'(g_lane) < NUM_LANES;
        g_step    = '0;
        g_rst     = 1'b0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (32'(g_lane) == l) begin
                g_step = step[l];
                g_rst  = lane_rst[l];
            end
        end
        g_adv     = gnt_vld && g_lane_ok && (32'(g_step) == 32'(gnt_idx));
        g_last    = 32'(gnt_idx) == NUM_DET - 1;
        // A same-edge lane reset wins, so it also swallows the completing step.
        new_match = g_adv && g_last && !g_rst;
        next_step = g_last ? '0 : SW'(32'(gnt_idx) + 1);
        next_rr   = g_last ? '0 : PW'(32'(gnt_idx) + 1);
    end

    always_comb begin
        for (int k = 0; k < NUM_DET; k++) begin
            capture[k] = probe_val[k] && lane_ok[k] && (!pending[k] || gnt_hot[k]);
            drop[k]    = probe_val[k] && lane_ok[k] && pending[k] && !gnt_hot[k];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending <= '0;
            for (int k = 0; k < NUM_DET; k++) plane[k] <= '0;
        end else if (flush_i) begin
            pending <= '0;
        end else begin
            for (int k = 0; k < NUM_DET; k++) begin
                if (capture[k]) begin
                    pending[k] <= 1'b1;
                    plane[k]   <= hit_lane[k];
                end else if (gnt_hot[k]) begin
                    pending[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int l = 0; l < NUM_LANES; l++) step[l] <= '0;
        end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (flush_i || lane_rst[l]) begin
                    step[l] <= '0;
                end else if (g_adv && (32'(g_lane) == l)) begin
                    step[l] <= next_step;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr       <= '0;
            match_vld_q  <= 1'b0;
            match_lane_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            if (flush_i) begin
                rr_ptr <= '0;
            end else if (gnt_vld) begin
                rr_ptr <= next_rr;
            end

            if (flush_i) begin
                match_vld_q  <= 1'b0;
                match_lane_q <= '0;
            end else if (new_match) begin
                match_vld_q  <= 1'b1;
                match_lane_q <= g_lane;
            end else if (match_ready_i) begin
                match_vld_q  <= 1'b0;
            end

            if (!flush_i && (|drop)) begin
                overflow_q <= 1'b1;
            end else if (overflow_clr_i) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign match_valid_o = match_vld_q;
    assign match_lane_o  = match_lane_q;
    assign overflow_o    = overflow_q;
    assign busy_o        = (|pending) | match_vld_q;

endmodule

// File: tb/tb_rm_lane_sequencer.sv
// Directed bench for rm_lane_sequencer: chain matching, out-of-order hits, round-robin, stall/overflow, lane reset, flush and reset.
module tb_rm_lane_sequencer;

    localparam int ND = 4;
    localparam int CW = 5;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            flush_i = 1'b0;
    logic [ND*CW-1:0] lane_cnt_i = '0;
    logic            match_valid_o;
    logic            match_ready_i = 1'b1;
    logic [2:0]      match_lane_o;
    logic            overflow_o;
    logic            overflow_clr_i = 1'b0;
    logic            busy_o;

    int n_chk  = 0;
    int n_pass = 0;

    rm_lane_sequencer #(.NUM_DET(4), .NUM_LANES(5)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .lane_cnt_i     (lane_cnt_i),
        .match_valid_o  (match_valid_o),
        .match_ready_i  (match_ready_i),
        .match_lane_o   (match_lane_o),
        .overflow_o     (overflow_o),
        .overflow_clr_i (overflow_clr_i),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drv_hit(input int k, input int lane);
        lane_cnt_i[k*CW+4]      = 1'b1;
        lane_cnt_i[k*CW+1 +: 3] = 3'(lane);
    endtask

    task automatic drv_rst(input int k, input int lane);
        lane_cnt_i[k*CW]        = 1'b1;
        lane_cnt_i[k*CW+1 +: 3] = 3'(lane);
    endtask

    task automatic clr();
        lane_cnt_i = '0;
    endtask

    // One hit, then one idle cycle so it is granted before the next.
    task automatic hit_step(input int k, input int lane);
        drv_hit(k, lane);
        tick();
        clr();
        tick();
    endtask

    task automatic test_reset();
        #2;
        n_chk++; if (match_valid_o !== 1'b0) $display("FAIL rst_valid got %0b want 0", match_valid_o); else n_pass++;
        n_chk++; if (match_lane_o !== 3'd0) $display("FAIL rst_lane got %0d want 0", match_lane_o); else n_pass++;
        n_chk++; if (overflow_o !== 1'b0) $display("FAIL rst_overflow got %0b want 0", overflow_o); else n_pass++;
        n_chk++; if (busy_o !== 1'b0) $display("FAIL rst_busy got %0b want 0", busy_o); else n_pass++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_chain();
        hit_step(0, 2);
        hit_step(1, 2);
        hit_step(2, 2);
        drv_hit(3, 2);
        tick();
        clr();
        n_chk++; if (match_valid_o !== 1'b0) $display("FAIL chain_early got %0b want 0", match_valid_o); else n_pass++;
        tick();
        n_chk++; if (match_valid_o !== 1'b1) $display("FAIL chain_valid got %0b want 1", match_valid_o); else n_pass++;
        n_chk++; if (match_lane_o !== 3'd2) $display("FAIL chain_lane got %0d want 2", match_lane_o); else n_pass++;
        tick();
        n_chk++; if (match_valid_o !== 1'b0) $display("FAIL chain_one_cycle got %0b want 0", match_valid_o); else n_pass++;
    endtask

    task automatic test_out_of_order();
        hit_step(2, 1);
        n_chk++; if (match_valid_o !== 1'b0) $display("FAIL ooo_nomatch got %0b want 0", match_valid_o); else n_pass++;
        n_chk++; if (busy_o !== 1'b0) $display("FAIL ooo_consumed got %0b want 0", busy_o); else n_pass++;
        hit_step(0, 1);
        hit_step(1, 1);
        hit_step(2, 1);
        drv_hit(3, 1);
        tick();
        clr();
        tick();
        n_chk++; if (match_valid_o !== 1'b1 || match_lane_o !== 3'd1)
            $display("FAIL ooo_chain got valid=%0b lane=%0d want valid=1 lane=1", match_valid_o, match_lane_o);
        else n_pass++;
        tick();
    endtask

    task automatic test_round_robin();
        for (int k = 0; k < ND; k++) drv_hit(k, 0);
        tick();
        clr();
        for (int c = 1; c <= 4; c++) begin
            n_chk++; if (busy_o !== 1'b1 || match_valid_o !== 1'b0)
                $display("FAIL rr_cycle%0d got busy=%0b valid=%0b want busy=1 valid=0", c, busy_o, match_valid_o);
            else n_pass++;
            tick();
        end
        n_chk++; if (match_valid_o !== 1'b1 || match_lane_o !== 3'd0)
            $display("FAIL rr_match got valid=%0b lane=%0d want valid=1 lane=0", match_valid_o, match_lane_o);
        else n_pass++;
        tick();
        n_chk++; if (busy_o !== 1'b0) $display("FAIL rr_idle got %0b want 0", busy_o); else n_pass++;
    endtask

    task automatic test_stall_overflow();
        match_ready_i = 1'b0;
        hit_step(0, 3);
        hit_step(1, 3);
        hit_step(2, 3);
        drv_hit(3, 3);
        tick();
        clr();
        tick();
        n_chk++; if (match_valid_o !== 1'b1 || match_lane_o !== 3'd3)
            $display("FAIL stall_match got valid=%0b lane=%0d want valid=1 lane=3", match_valid_o, match_lane_o);
        else n_pass++;
        for (int s = 0; s < 5; s++) begin
            if (s == 0 || s == 2) drv_hit(0, 3);
            tick();
            clr();
            n_chk++; if (match_valid_o !== 1'b1 || match_lane_o !== 3'd3)
                $display("FAIL stall_hold%0d got valid=%0b lane=%0d want valid=1 lane=3", s, match_valid_o, match_lane_o);
            else n_pass++;
        end
        n_chk++; if (overflow_o !== 1'b1) $display("FAIL stall_overflow got %0b want 1", overflow_o); else n_pass++;
        n_chk++; if (busy_o !== 1'b1) $display("FAIL stall_busy got %0b want 1", busy_o); else n_pass++;
        match_ready_i = 1'b1;
        tick();
        n_chk++; if (match_valid_o !== 1'b0) $display("FAIL stall_release got %0b want 0", match_valid_o); else n_pass++;
        n_chk++; if (busy_o !== 1'b0) $display("FAIL stall_drain got %0b want 0", busy_o); else n_pass++;
        n_chk++; if (overflow_o !== 1'b1) $display("FAIL overflow_sticky got %0b want 1", overflow_o); else n_pass++;
        overflow_clr_i = 1'b1;
        tick();
        overflow_clr_i = 1'b0;
        n_chk++; if (overflow_o !== 1'b0) $display("FAIL overflow_clr got %0b want 0", overflow_o); else n_pass++;
        drv_rst(0, 3);
        tick();
        clr();
    endtask

    task automatic test_lane_reset();
        hit_step(0, 4);
        hit_step(1, 4);
        hit_step(2, 4);
        drv_hit(3, 4);
        tick();
        clr();
        drv_rst(1, 4);
        tick();
        clr();
        n_chk++; if (match_valid_o !== 1'b0) $display("FAIL lrst_suppress got %0b want 0", match_valid_o); else n_pass++;
        tick();
        n_chk++; if (match_valid_o !== 1'b0 || busy_o !== 1'b0)
            $display("FAIL lrst_idle got valid=%0b busy=%0b want 0 0", match_valid_o, busy_o);
        else n_pass++;
        hit_step(0, 4);
        hit_step(1, 4);
        hit_step(2, 4);
        drv_hit(3, 4);
        tick();
        clr();
        tick();
        n_chk++; if (match_valid_o !== 1'b1 || match_lane_o !== 3'd4)
            $display("FAIL lrst_rechain got valid=%0b lane=%0d want valid=1 lane=4", match_valid_o, match_lane_o);
        else n_pass++;
        tick();
    endtask

    task automatic test_flush_and_reset();
        // Flush mid-chain with a dropped hit: overflow survives, everything else clears.
        hit_step(0, 2);
        hit_step(1, 2);
        for (int k = 0; k < ND; k++) drv_hit(k, 2);
        tick();
        tick();
        clr();
        n_chk++; if (overflow_o !== 1'b1) $display("FAIL collide_overflow got %0b want 1", overflow_o); else n_pass++;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        n_chk++; if (match_valid_o !== 1'b0 || busy_o !== 1'b0 || match_lane_o !== 3'd0)
            $display("FAIL flush_clear got valid=%0b busy=%0b lane=%0d want 0 0 0", match_valid_o, busy_o, match_lane_o);
        else n_pass++;
        n_chk++; if (overflow_o !== 1'b1) $display("FAIL flush_keeps_overflow got %0b want 1", overflow_o); else n_pass++;
        hit_step(2, 2);
        hit_step(3, 2);
        n_chk++; if (match_valid_o !== 1'b0) $display("FAIL flush_steps got %0b want 0", match_valid_o); else n_pass++;

        // Async reset mid-chain with a slot pending.
        hit_step(0, 2);
        hit_step(1, 2);
        drv_hit(2, 2);
        tick();
        clr();
        #2;
        rst_ni = 1'b0;
        #1;
        n_chk++; if (match_valid_o !== 1'b0 || busy_o !== 1'b0 || overflow_o !== 1'b0 || match_lane_o !== 3'd0)
            $display("FAIL midrst got valid=%0b busy=%0b ovf=%0b lane=%0d want 0 0 0 0",
                     match_valid_o, busy_o, overflow_o, match_lane_o);
        else n_pass++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        hit_step(2, 2);
        hit_step(3, 2);
        n_chk++; if (match_valid_o !== 1'b0) $display("FAIL midrst_steps got %0b want 0", match_valid_o); else n_pass++;
        hit_step(0, 2);
        hit_step(1, 2);
        hit_step(2, 2);
        drv_hit(3, 2);
        tick();
        clr();
        tick();
        n_chk++; if (match_valid_o !== 1'b1 || match_lane_o !== 3'd2)
            $display("FAIL fresh_chain got valid=%0b lane=%0d want valid=1 lane=2", match_valid_o, match_lane_o);
        else n_pass++;
        tick();
        n_chk++; if (match_valid_o !== 1'b0) $display("FAIL fresh_clear got %0b want 0", match_valid_o); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_chain();
        test_out_of_order();
        test_round_robin();
        test_stall_overflow();
        test_lane_reset();
        test_flush_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
